// File: rtl/uart_tx_fifo_if.sv
// rtl/uart_tx_fifo_if.sv - word handshake between the register port and the UART transmitter
interface uart_tx_fifo_if #(
    parameter int DATA_BITS = 8
);
    logic                 valid;
    logic [DATA_BITS-1:0] data;
    logic                 ready;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - UART transmitter fed by a small word FIFO, back-to-back framing
module uart_tx_fifo #(
    parameter int CLK_DIVIDE = 868,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        i_clk,
    input  logic                        i_resetn,
    uart_tx_fifo_if.slave               bus,
    output logic                        serial_out,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(CLK_DIVIDE);
    localparam int BW = $clog2(DATA_BITS + 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t               state;
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [DATA_BITS-1:0] shift;
    logic [DATA_BITS-1:0] head;
    logic                 par_bit;
    logic [CW-1:0]        clk_cnt;
    logic [BW-1:0]        bit_cnt;
    logic                 push;
    logic                 pop;
    logic                 last_tick;
    logic                 stop_done;

    assign bus.ready = (level != LW'(FIFO_DEPTH));
    assign push      = bus.valid && bus.ready;
    assign head      = mem[rd_ptr];
    assign last_tick = (clk_cnt == CW'(CLK_DIVIDE - 1));
    assign stop_done = last_tick && (bit_cnt == BW'(STOP_BITS - 1));
    // Popping at the end of the last stop period lets the next start bit follow with no idle gap.
    assign pop = (level != '0) && ((state == S_IDLE) || (state == S_STOP && stop_done));

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.data;
        end
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop) begin
                level <= level + 1'b1;
            end else if (pop && !push) begin
                level <= level - 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            state      <= S_IDLE;
            serial_out <= 1'b1;
            busy       <= 1'b0;
            clk_cnt    <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            par_bit    <= 1'b0;
        end else if (pop) begin
            shift      <= head;
            par_bit    <= (PARITY == 2) ? ~^head : ^head;
            clk_cnt    <= '0;
            bit_cnt    <= '0;
            serial_out <= 1'b0;
            busy       <= 1'b1;
            state      <= S_START;
        end else begin
            case (state)
                S_IDLE: begin
                    serial_out <= 1'b1;
                    busy       <= 1'b0;
                end
                default: begin
                    if (!last_tick) begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end else begin
                        clk_cnt <= '0;
                        case (state)
                            S_START: begin
                                serial_out <= shift[0];
                                bit_cnt    <= '0;
                                state      <= S_DATA;
                            end
                            S_DATA: begin
                                if (bit_cnt == BW'(DATA_BITS - 1)) begin
                                    bit_cnt <= '0;
                                    if (PARITY != 0) begin
                                        serial_out <= par_bit;
                                        state      <= S_PARITY;
                                    end else begin
                                        serial_out <= 1'b1;
                                        state      <= S_STOP;
                                    end
                                end else begin
                                    bit_cnt    <= bit_cnt + 1'b1;
                                    shift      <= shift >> 1;
                                    serial_out <= shift[1];
                                end
                            end
                            S_PARITY: begin
                                serial_out <= 1'b1;
                                bit_cnt    <= '0;
                                state      <= S_STOP;
                            end
                            S_STOP: begin
                                if (bit_cnt == BW'(STOP_BITS - 1)) begin
                                    serial_out <= 1'b1;
                                    busy       <= 1'b0;
                                    state      <= S_IDLE;
                                end else begin
                                    bit_cnt <= bit_cnt + 1'b1;
                                end
                            end
                            default: state <= S_IDLE;
                        endcase
                    end
                end
            endcase
        end
    end
endmodule
